// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision mantissa multiplier.
//   state_e  : controller states (IDLE / BUSY / DONE)
//   fp32_t   : IEEE-754 single-precision field layout
//   mant_of  : extracts {hidden, fraction} from a packed operand
package fpu_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned ITERS  = 12;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned A3_W   = MANT_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // The hidden bit is set for every non-zero exponent (denormals/zero give 0).
  function automatic logic [MANT_W-1:0] mant_of(input fp32_t op);
    return {(op.exp != 8'd0), op.frac};
  endfunction

endpackage

// File: rtl/fpu_r4_step.sv
// One radix-4 step: pick 0/A/2A/3A from a multiplier digit and add it to the
// accumulator at weight 4^count.
//   acc_i     : running accumulator
//   a_i       : multiplicand A
//   a3_i      : precomputed 3A
//   digit_i   : current two-bit multiplier digit
//   count_i   : iteration index (digit weight)
//   acc_nxt_c : accumulator after this step (combinational)
module fpu_r4_step
  import fpu_pkg::*;
(
  input  logic [PROD_W-1:0] acc_i,
  input  logic [MANT_W-1:0] a_i,
  input  logic [A3_W-1:0]   a3_i,
  input  logic [1:0]        digit_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic [PROD_W-1:0] acc_nxt_c
);

  logic [A3_W-1:0]   pp;
  logic [PROD_W-1:0] pp_sh;

  always_comb begin
    pp = '0;
    unique case (digit_i)
      2'd0:    pp = '0;
      2'd1:    pp = A3_W'(a_i);
      2'd2:    pp = A3_W'({a_i, 1'b0});
      default: pp = a3_i;
    endcase
    // Never overflows: the partial sum is always below the final 48-bit product.
    pp_sh     = PROD_W'(pp) << {count_i, 1'b0};
    acc_nxt_c = acc_i + pp_sh;
  end

endmodule

// File: rtl/fpu_mant_mult.sv
// Iterative 24x24 mantissa multiplier, two multiplier bits per cycle.
//   clock, reset_n      : clock, async active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   opa, opb            : IEEE-754 single-precision operands
//   flush               : synchronous squash, highest priority
//   out_valid/out_ready : product handshake (valid only in DONE)
//   opa_q, opb_q        : captured operands, forwarded unchanged
//   mult_result         : exact unsigned 48-bit mantissa product
module fpu_mant_mult #(
  parameter int unsigned ITERS = fpu_pkg::ITERS
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [fpu_pkg::OP_W-1:0]   opa,
  input  logic [fpu_pkg::OP_W-1:0]   opb,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [fpu_pkg::OP_W-1:0]   opa_q,
  output logic [fpu_pkg::OP_W-1:0]   opb_q,
  output logic [fpu_pkg::PROD_W-1:0] mult_result
);

  import fpu_pkg::*;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [MANT_W-1:0]   a_q, b_q, a_d;
  logic [A3_W-1:0]     a3_q, a3_d;
  logic [PROD_W-1:0]   acc_q, acc_nxt;
  logic [CNT_W-1:0]    count_q;
  logic [OP_W-1:0]     opa_r_q, opb_r_q;
  logic                accept, step, last, hshake;

  // Flush outranks every other event in the same cycle.
  assign accept = in_valid & in_ready_q & ~flush;
  assign step   = (state_q == BUSY) & ~flush;
  assign last   = (count_q == CNT_W'(ITERS - 1));
  assign hshake = out_valid_q & out_ready & ~flush;

  assign a_d  = mant_of(opa);
  assign a3_d = A3_W'(a_d) + (A3_W'(a_d) << 1);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = BUSY;
        BUSY:    if (last)   state_d = DONE;
        DONE:    if (hshake) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake flags are decoded from the upcoming state so they are registered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  fpu_r4_step u_step (
    .acc_i     (acc_q),
    .a_i       (a_q),
    .a3_i      (a3_q),
    .digit_i   (b_q[1:0]),
    .count_i   (count_q),
    .acc_nxt_c (acc_nxt)
  );

  // Operand capture and iteration datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opa_r_q <= '0;
      opb_r_q <= '0;
      a_q     <= '0;
      a3_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      opa_r_q <= opa;
      opb_r_q <= opb;
      a_q     <= a_d;
      a3_q    <= a3_d;
      b_q     <= mant_of(opb);
      acc_q   <= '0;
      count_q <= '0;
    end else if (step) begin
      acc_q   <= acc_nxt;
      b_q     <= b_q >> 2;
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign opa_q       = opa_r_q;
  assign opb_q       = opb_r_q;
  assign mult_result = acc_q;

endmodule

// File: tb/tb_fpu_mant_mult.sv
// Scoreboard bench for fpu_mant_mult: directed vectors, back-pressure hold,
// flush, mid-operation reset and randomized operands against a plain
// arithmetic mantissa-product model.
module tb_fpu_mant_mult;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [47:0] mult_result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int or_mode = 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [47:0] p;
    int          acc_cyc;
  } exp_t;
  exp_t q[$];

  fpu_mant_mult #(.ITERS(12)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opa         (opa),
    .opb         (opb),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opa_q       (opa_q),
    .opb_q       (opb_q),
    .mult_result (mult_result)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total = total + 1;
    if (act !== exp_v) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: product of the two 24-bit mantissas, hidden bit from exponent.
  function automatic logic [47:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [23:0] ma, mb;
    ma = {(a[30:23] != 8'd0), a[22:0]};
    mb = {(b[30:23] != 8'd0), b[22:0]};
    return 48'(ma) * 48'(mb);
  endfunction

  // Consumer-ready driver: 0 = held low, 1 = held high, else random.
  initial forever begin
    @(posedge clock);
    #2;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency on first valid cycle, payload on handshake.
  initial begin
    bit lat_done;
    lat_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n || !out_valid) begin
        lat_done = 1'b0;
      end else if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!lat_done) begin
          chk("latency", 64'(cyc - q[0].acc_cyc), 64'd12);
          lat_done = 1'b1;
        end
        if (out_ready) begin
          chk("mult_result", 64'(mult_result), 64'(q[0].p));
          chk("opa_q", 64'(opa_q), 64'(q[0].a));
          chk("opb_q", 64'(opb_q), 64'(q[0].b));
          void'(q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [47:0] p, output int acc_cyc);
    int n;
    n = 0;
    @(posedge clock);
    #2;
    while (!in_ready && n < 300) begin
      @(posedge clock);
      #2;
      n = n + 1;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      acc_cyc = -1;
      return;
    end
    in_valid = 1'b1;
    opa = a;
    opb = b;
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    q.push_back('{a, b, p, cyc});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n = n + 1;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int ac0, ac1, n;
    logic [31:0] ra, rb;

    // Reset values while held in reset.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mult_result", 64'(mult_result), 64'd0);
    chk("rst_opa_q", 64'(opa_q), 64'd0);
    chk("rst_opb_q", 64'(opb_q), 64'd0);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors and throughput with the consumer always ready.
    or_mode = 1;
    issue(32'h3F800000, 32'h3F800000, 48'h400000000000, ac0);
    issue(32'h3FC00000, 32'h3FC00000, 48'h900000000000, ac1);
    chk("throughput", 64'(ac1 - ac0), 64'd14);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 48'hFFFFFE000001, ac0);
    issue(32'h00000000, 32'h3F800000, 48'h000000000000, ac0);
    drain();

    // Back-pressure in DONE: outputs hold, new operands ignored.
    or_mode = 0;
    issue(32'h3F800000, 32'h3FC00000, 48'h600000000000, ac0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n = n + 1;
    end
    chk("hold_valid_wait", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #2;
      in_valid = 1'b1;
      opa = $urandom;
      opb = $urandom;
      @(negedge clock);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(mult_result), 64'h600000000000);
      chk("hold_opa_q", 64'(opa_q), 64'h3F800000);
      chk("hold_opb_q", 64'(opb_q), 64'h3FC00000);
    end
    in_valid = 1'b0;
    or_mode = 1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // Flush on the 6th BUSY cycle.
    issue(32'h7F7FFFFF, 32'h3FC00000, 48'h0, ac0);
    repeat (5) @(posedge clock);
    #2;
    flush = 1'b1;
    @(posedge clock);
    #1;
    q.delete();
    #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (16) @(negedge clock);
    chk("flush_no_valid", 64'(out_valid), 64'd0);
    issue(32'h3FC00000, 32'h3FC00000, 48'h900000000000, ac0);
    drain();

    // Reset asserted mid-BUSY.
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 48'h0, ac0);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_mult_result", 64'(mult_result), 64'd0);
    chk("mrst_opa_q", 64'(opa_q), 64'd0);
    chk("mrst_opb_q", 64'(opb_q), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("mrst_idle_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_idle_out_valid", 64'(out_valid), 64'd0);

    // Randomized operands with random consumer back-pressure.
    or_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[30:23] = 8'd0;
      issue(ra, rb, ref_prod(ra, rb), ac0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
